// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared datapath/register widths and FSM state type for the MEM stage.
package mem_stage_pkg;
  localparam int DATA_W = 16;
  localparam int REG_W = 3;
  typedef enum logic {IDLE, BUSY} state_e;
endpackage

// File: rtl/mem_stage_dmem_ram.sv
// dmem_ram: single-port data memory, synchronous write, combinational read, no reset.
module dmem_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[addr_i] <= wdata_i;
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with multi-cycle data memory access and registered MEM/WB outputs.
// Define MEM_BOUND_CHECK_EN to reject out-of-range addresses and raise the sticky err flag.
module mem_stage #(
  parameter int DATA_W = mem_stage_pkg::DATA_W,
  parameter int DEPTH = 64,
  parameter int MEM_LAT = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid_in,
  input  logic [DATA_W-1:0]              alu_res,
  input  logic [DATA_W-1:0]              st_data,
  input  logic [mem_stage_pkg::REG_W-1:0] dest_in,
  input  logic                           wb_en_in,
  input  logic                           mem_rd,
  input  logic                           mem_wr,
  input  logic                           flush,
  output logic                           stall,
  output logic [DATA_W-1:0]              alu_res_out,
  output logic [DATA_W-1:0]              mem_res,
  output logic [mem_stage_pkg::REG_W-1:0] wb_dest,
  output logic                           alu_mem_bar,
  output logic                           wb_en,
  output logic                           valid_out,
  output logic                           err
);
  import mem_stage_pkg::*;
  localparam int AW = $clog2(DEPTH);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] alu_q, alu_d, mres_q, mres_d, rdata;
  logic [REG_W-1:0] dest_q, dest_d;
  logic amb_q, amb_d, wben_q, wben_d, vld_q, vld_d, err_q, err_d;
  logic mem_op, done, acc, bad, we;
  logic [AW-1:0] addr;
  assign addr = AW'(alu_res % DEPTH);
  dmem_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk(clk), .we_i(we), .addr_i(addr), .wdata_i(st_data), .rdata_o(rdata)
  );
  always_comb begin
    mem_op = mem_rd | mem_wr;
    done = state_q == BUSY && cnt_q == '0;
    acc = done && valid_in && mem_op && !flush;
    stall = valid_in && mem_op && !done && !flush;
`ifdef MEM_BOUND_CHECK_EN
    bad = 32'(alu_res) >= 32'(DEPTH);
`else
    bad = 1'b0;
`endif
    // rst blocks the write so an abandoned access never reaches memory
    we = acc && mem_wr && !bad && !rst;
    err_d = err_q | (acc & bad);
    state_d = IDLE;
    cnt_d = '0;
    alu_d = '0;
    mres_d = '0;
    dest_d = '0;
    amb_d = 1'b0;
    wben_d = 1'b0;
    vld_d = 1'b0;
    if (!flush) begin
      if (state_q == IDLE && valid_in && mem_op) begin
        state_d = BUSY;
        cnt_d = 4'(MEM_LAT - 1);
      end else if (state_q == IDLE && valid_in) begin
        alu_d = alu_res;
        dest_d = dest_in;
        amb_d = 1'b1;
        wben_d = wb_en_in;
        vld_d = 1'b1;
      end else if (state_q == BUSY && !done) begin
        state_d = BUSY;
        cnt_d = cnt_q - 4'd1;
      end else if (acc) begin
        alu_d = alu_res;
        dest_d = dest_in;
        mres_d = (mem_rd && !bad) ? rdata : '0;
        wben_d = mem_rd & wb_en_in;
        vld_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      alu_q <= '0;
      mres_q <= '0;
      dest_q <= '0;
      amb_q <= 1'b0;
      wben_q <= 1'b0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      alu_q <= alu_d;
      mres_q <= mres_d;
      dest_q <= dest_d;
      amb_q <= amb_d;
      wben_q <= wben_d;
      vld_q <= vld_d;
      err_q <= err_d;
    end
  end
  assign alu_res_out = alu_q;
  assign mem_res = mres_q;
  assign wb_dest = dest_q;
  assign alu_mem_bar = amb_q;
  assign wb_en = wben_q;
  assign valid_out = vld_q;
  assign err = err_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed plus randomized transactions against a transaction-level model of the MEM stage.
module tb_mem_stage;
  localparam int DEPTH = 64;
  localparam int MEM_LAT = 2;
  logic clk = 1'b0, rst, valid_in, wb_en_in, mem_rd, mem_wr, flush;
  logic [15:0] alu_res, st_data, alu_res_out, mem_res;
  logic [2:0] dest_in, wb_dest;
  logic stall, alu_mem_bar, wb_en, valid_out, err;
  logic [15:0] ref_mem [DEPTH];
  bit err_ref;
  int total = 0, passes = 0;
  always #5 clk = ~clk;
  mem_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_res(alu_res), .st_data(st_data),
    .dest_in(dest_in), .wb_en_in(wb_en_in), .mem_rd(mem_rd), .mem_wr(mem_wr), .flush(flush),
    .stall(stall), .alu_res_out(alu_res_out), .mem_res(mem_res), .wb_dest(wb_dest),
    .alu_mem_bar(alu_mem_bar), .wb_en(wb_en), .valid_out(valid_out), .err(err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask
  task automatic outs(input logic [15:0] a, m, input logic [2:0] d, input bit amb, we, v);
    chk("alu_res_out", alu_res_out, a);
    chk("mem_res", mem_res, m);
    chk("wb_dest", wb_dest, d);
    chk("alu_mem_bar", alu_mem_bar, amb);
    chk("wb_en", wb_en, we);
    chk("valid_out", valid_out, v);
    chk("err", err, err_ref);
  endtask
  // one instruction; fl = index of the cycle carrying flush (-1 for none)
  task automatic op(input bit vin, rd, wr, input logic [15:0] a, d, input logic [2:0] dst,
                    input bit wbi, input int fl);
    bit mem, oob, cut;
    int n;
    logic [15:0] v;
    mem = vin && (rd || wr);
    n = mem ? MEM_LAT : 0;
    if (fl > n) fl = -1;
    cut = fl >= 0;
    if (cut) n = fl;
    oob = 1'b0;
`ifdef MEM_BOUND_CHECK_EN
    oob = a >= DEPTH;
`endif
    v = oob ? 16'h0 : ref_mem[a % DEPTH];
    valid_in = vin; mem_rd = rd; mem_wr = wr; alu_res = a; st_data = d;
    dest_in = dst; wb_en_in = wbi;
    for (int k = 0; k <= n; k++) begin
      flush = (k == fl);
      #1 chk("stall", stall, mem && k < MEM_LAT && k != fl);
      @(posedge clk);
      #1;
      if (k < n || cut || !vin) outs(0, 0, 0, 0, 0, 0);
      else if (!mem) outs(a, 0, dst, 1, wbi, 1);
      else begin
        if (oob) err_ref = 1'b1;
        if (wr && !oob) ref_mem[a % DEPTH] = d;
        outs(a, rd ? v : 16'h0, dst, 0, rd & wbi, 1);
      end
    end
    flush = 1'b0;
  endtask
  initial begin
    rst = 1'b1; valid_in = 0; mem_rd = 0; mem_wr = 0; flush = 0; wb_en_in = 0;
    alu_res = 0; st_data = 0; dest_in = 0; err_ref = 0;
    repeat (2) @(posedge clk);
    #1 outs(0, 0, 0, 0, 0, 0);
    chk("stall_reset", stall, 0);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) op(1, 0, 1, 16'(i), 16'($urandom), 3'(i), 1, -1);
    op(1, 0, 0, 16'h1234, 16'h0, 3'd5, 1, -1);
    op(1, 0, 1, 16'd3, 16'hBEEF, 3'd1, 1, -1);
    op(1, 1, 0, 16'd3, 16'h0, 3'd2, 1, -1);
    op(1, 0, 1, 16'd7, 16'hA5A5, 3'd3, 1, 1);
    op(1, 1, 0, 16'd7, 16'h0, 3'd4, 1, -1);
    op(1, 0, 1, 16'd9, 16'h5555, 3'd3, 1, MEM_LAT);
    op(1, 0, 1, 16'd9, 16'h6666, 3'd3, 1, 0);
    op(1, 1, 0, 16'd9, 16'h0, 3'd6, 0, -1);
    op(0, 1, 0, 16'd9, 16'h0, 3'd6, 1, -1);
    op(1, 1, 0, 16'h0040, 16'h0, 3'd7, 1, -1);
    op(1, 0, 0, 16'h0011, 16'h0, 3'd2, 0, -1);
    for (int i = 0; i < 300; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      op(kind != 0, kind == 2, kind == 3, 16'($urandom_range(0, 79)), 16'($urandom),
         3'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0) ? $urandom_range(0, MEM_LAT) : -1);
    end
    valid_in = 1; mem_rd = 1; mem_wr = 0; alu_res = 16'd5; flush = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; valid_in = 0; mem_rd = 0;
    err_ref = 1'b0;
    outs(0, 0, 0, 0, 0, 0);
    #1 chk("stall_after_rst", stall, 0);
    op(1, 1, 0, 16'd5, 16'h0, 3'd1, 1, -1);
    op(1, 0, 0, 16'h00FF, 16'h0, 3'd2, 1, -1);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
